// File: rtl/cd_sector_rx_pkg.sv
// Shared constants and status-word helpers for the HPS CD sector receiver.
package cd_sector_rx_pkg;

   localparam logic [15:0] CD_GET = 16'h0034;
   localparam logic [15:0] CD_SET = 16'h0035;

   localparam int SECTOR_WORDS_DEF = 1176;
   localparam int LBA_W_DEF        = 24;

   localparam int ST_PEND   = 15;
   localparam int ST_STAGED = 14;
   localparam int ST_VALID  = 13;
   localparam int ST_ERR    = 12;
   localparam int ST_SEQ    = 8;

   function automatic logic [15:0] status_w0(
      input logic       pend,
      input logic       staged,
      input logic       valid,
      input logic       err,
      input logic [3:0] seq
   );
      logic [15:0] w;
      w              = '0;
      w[ST_PEND]     = pend;
      w[ST_STAGED]   = staged;
      w[ST_VALID]    = valid;
      w[ST_ERR]      = err;
      w[ST_SEQ +: 4] = seq;
      return w;
   endfunction

   // lba arrives zero-extended, so its upper half is the w2 word
   function automatic logic [15:0] status_word(
      input logic [11:0] k,
      input logic [15:0] w0,
      input logic [31:0] lba
   );
      logic [15:0] w;
      case (k)
         12'd0:   w = w0;
         12'd1:   w = lba[15:0];
         12'd2:   w = lba[31:16];
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/cd_sector_ram.sv
// Two-bank sector buffer: simple dual-port RAM with a registered read port.
module cd_sector_ram
   import cd_sector_rx_pkg::*;
#(
   parameter int WORDS = SECTOR_WORDS_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic        wbank_i,
   input  logic [10:0] waddr_i,
   input  logic [15:0] wdata_i,
   input  logic        rbank_i,
   input  logic [10:0] raddr_i,
   output logic [15:0] rdata_o
);

   localparam int          DEPTH = 2 * WORDS;
   localparam logic [10:0] LIM   = 11'(WORDS);

   logic [15:0] mem_q [DEPTH];
   logic [15:0] rdata_q;
   logic [11:0] wa;
   logic [11:0] ra;

   assign wa = {1'b0, waddr_i} + (wbank_i ? 12'(WORDS) : 12'd0);
   assign ra = {1'b0, raddr_i} + (rbank_i ? 12'(WORDS) : 12'd0);

   always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i < LIM)) begin
         mem_q[wa] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (raddr_i < LIM) begin
         rdata_q <= mem_q[ra];
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cd_sector_rx.sv
// CD_GET/CD_SET endpoint: reports the drive's sector request and
// double-buffers delivered raw sectors for the drive core.
module cd_sector_rx
   import cd_sector_rx_pkg::*;
#(
   parameter int SECTOR_WORDS = SECTOR_WORDS_DEF,
   parameter int LBA_W        = LBA_W_DEF
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             ext_sel,
   input  logic [15:0]      ext_cmd,
   input  logic             ext_strobe,
   input  logic [15:0]      ext_din,
   output logic [15:0]      ext_dout,
   input  logic             req_valid,
   input  logic [LBA_W-1:0] req_lba,
   output logic             req_ready,
   output logic             sector_valid,
   output logic [LBA_W-1:0] sector_lba,
   input  logic [10:0]      sector_rd_addr,
   output logic [15:0]      sector_rd_data,
   input  logic             sector_ack
);

   localparam logic [10:0] WEND = 11'(SECTOR_WORDS + 2);

   logic             sel_q, sel_d;
   logic             fall_q, fall_d;
   logic             get_q, get_d;
   logic             set_q, set_d;
   logic [10:0]      idx_q, idx_d;
   logic [15:0]      dout_q, dout_d;
   logic [LBA_W-1:0] snap_lba_q, snap_lba_d;
   logic [LBA_W-1:0] rx_lba_q, rx_lba_d;
   logic             pend_q, pend_d;
   logic [LBA_W-1:0] pend_lba_q, pend_lba_d;
   logic [3:0]       seq_q, seq_d;
   logic             err_q, err_d;
   logic             staged_q, staged_d;
   logic [LBA_W-1:0] stg_lba_q, stg_lba_d;
   logic             valid_q, valid_d;
   logic [LBA_W-1:0] lba_q, lba_d;
   logic             bank_q, bank_d;
   logic             reload_q, reload_d;

   logic             rise, fall, is_get, is_set, stb;
   logic             ack_v, cap, commit_ok, commit_bad;
   logic             vld_eff, we;
   logic [10:0]      wk, waddr;
   logic [15:0]      w0;
   logic [LBA_W-1:0] src_lba;

   assign rise    = ext_sel & ~sel_q;
   assign fall    = sel_q & ~ext_sel;
   assign is_get  = rise ? (ext_cmd == CD_GET) : get_q;
   assign is_set  = rise ? (ext_cmd == CD_SET) : set_q;
   // a strobe landing with the falling edge still belongs to the transfer
   assign stb     = ext_strobe & (ext_sel | sel_q);
   assign wk      = rise ? 11'd0 : idx_q;
   assign src_lba = rise ? pend_lba_q : snap_lba_q;
   assign w0      = status_w0(pend_q, staged_q, valid_q, err_q, seq_q);

   assign we    = stb & is_set & ~staged_q & (wk >= 11'd2) & (wk < WEND);
   assign waddr = wk - 11'd2;

   assign commit_ok = fall_q & set_q & pend_q & (idx_q == WEND)
                    & (rx_lba_q == pend_lba_q);
   assign commit_bad = fall_q & set_q & ~commit_ok;

   assign ack_v     = sector_ack & valid_q;
   assign req_ready = reset_n & ~pend_q & ~staged_q;
   assign cap       = req_valid & req_ready;

   always_comb begin
      sel_d      = ext_sel;
      fall_d     = fall;
      get_d      = get_q;
      set_d      = set_q;
      idx_d      = idx_q;
      dout_d     = dout_q;
      snap_lba_d = snap_lba_q;
      rx_lba_d   = rx_lba_q;
      pend_d     = pend_q;
      pend_lba_d = pend_lba_q;
      seq_d      = seq_q;
      err_d      = err_q;
      staged_d   = staged_q;
      stg_lba_d  = stg_lba_q;
      valid_d    = valid_q;
      lba_d      = lba_q;
      bank_d     = bank_q;
      reload_d   = 1'b0;
      vld_eff    = valid_q;

      if (rise) begin
         idx_d      = '0;
         get_d      = (ext_cmd == CD_GET);
         set_d      = (ext_cmd == CD_SET);
         snap_lba_d = pend_lba_q;
         if (is_get) dout_d = status_word(12'd0, w0, 32'(pend_lba_q));
      end

      if (stb) begin
         idx_d = (wk == 11'h7FF) ? wk : wk + 11'd1;
         if (is_get) begin
            dout_d = status_word({1'b0, wk} + 12'd1, w0, 32'(src_lba));
         end
         if (is_set && wk == 11'd0) rx_lba_d[15:0] = ext_din;
         if (is_set && wk == 11'd1) begin
            rx_lba_d[LBA_W-1:16] = ext_din[LBA_W-17:0];
         end
      end

      if (fall) dout_d = '0;

      if (reload_q) begin
         valid_d  = 1'b1;
         lba_d    = stg_lba_q;
         bank_d   = ~bank_q;
         staged_d = 1'b0;
      end

      // ack is resolved before a same-cycle commit looks at sector_valid
      if (ack_v) begin
         valid_d  = 1'b0;
         vld_eff  = 1'b0;
         reload_d = staged_q;
      end

      if (commit_ok) begin
         pend_d = 1'b0;
         err_d  = 1'b0;
         if (!vld_eff) begin
            bank_d  = ~bank_q;
            valid_d = 1'b1;
            lba_d   = rx_lba_q;
         end else begin
            staged_d  = 1'b1;
            stg_lba_d = rx_lba_q;
         end
      end

      if (commit_bad) err_d = 1'b1;

      if (cap) begin
         pend_d     = 1'b1;
         pend_lba_d = req_lba;
         seq_d      = seq_q + 4'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sel_q      <= 1'b0;
         fall_q     <= 1'b0;
         get_q      <= 1'b0;
         set_q      <= 1'b0;
         idx_q      <= '0;
         dout_q     <= '0;
         snap_lba_q <= '0;
         rx_lba_q   <= '0;
         pend_q     <= 1'b0;
         pend_lba_q <= '0;
         seq_q      <= '0;
         err_q      <= 1'b0;
         staged_q   <= 1'b0;
         stg_lba_q  <= '0;
         valid_q    <= 1'b0;
         lba_q      <= '0;
         bank_q     <= 1'b0;
         reload_q   <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         fall_q     <= fall_d;
         get_q      <= get_d;
         set_q      <= set_d;
         idx_q      <= idx_d;
         dout_q     <= dout_d;
         snap_lba_q <= snap_lba_d;
         rx_lba_q   <= rx_lba_d;
         pend_q     <= pend_d;
         pend_lba_q <= pend_lba_d;
         seq_q      <= seq_d;
         err_q      <= err_d;
         staged_q   <= staged_d;
         stg_lba_q  <= stg_lba_d;
         valid_q    <= valid_d;
         lba_q      <= lba_d;
         bank_q     <= bank_d;
         reload_q   <= reload_d;
      end
   end

   cd_sector_ram #(
      .WORDS (SECTOR_WORDS)
   ) u_ram (
      .clk_i   (clk_sys),
      .rst_ni  (reset_n),
      .we_i    (we),
      .wbank_i (~bank_q),
      .waddr_i (waddr),
      .wdata_i (ext_din),
      .rbank_i (bank_q),
      .raddr_i (sector_rd_addr),
      .rdata_o (sector_rd_data)
   );

   assign ext_dout     = dout_q;
   assign sector_valid = valid_q;
   assign sector_lba   = lba_q;

endmodule

// File: tb/tb_cd_sector_rx.sv
// Bench for cd_sector_rx: directed table, corner sequences and
// random transactions checked against a transaction-level model.
module tb_cd_sector_rx;
   import cd_sector_rx_pkg::*;

   localparam int SW = SECTOR_WORDS_DEF;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ext_sel = 1'b0;
   logic [15:0] ext_cmd = '0;
   logic        ext_strobe = 1'b0;
   logic [15:0] ext_din = '0;
   logic [15:0] ext_dout;
   logic        req_valid = 1'b0;
   logic [23:0] req_lba = '0;
   logic        req_ready;
   logic        sector_valid;
   logic [23:0] sector_lba;
   logic [10:0] sector_rd_addr = '0;
   logic [15:0] sector_rd_data;
   logic        sector_ack = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   // transaction-level model of the externally visible state
   bit          m_pend, m_staged, m_valid, m_err;
   int          m_seq;
   logic [23:0] m_plba, m_slba, m_stlba;
   logic [15:0] m_rmask, m_smask;

   typedef enum {OP_REQ, OP_SET, OP_ACK} op_e;
   typedef struct {
      op_e         op;
      logic [23:0] lba;
      int          n;
      logic [15:0] mask;
      logic [15:0] w0;
      logic        valid;
      logic [23:0] slba;
      logic        ready;
   } vec_t;

   vec_t tbl [9];

   always #5 clk_sys = ~clk_sys;

   cd_sector_rx dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ext_sel        (ext_sel),
      .ext_cmd        (ext_cmd),
      .ext_strobe     (ext_strobe),
      .ext_din        (ext_din),
      .ext_dout       (ext_dout),
      .req_valid      (req_valid),
      .req_lba        (req_lba),
      .req_ready      (req_ready),
      .sector_valid   (sector_valid),
      .sector_lba     (sector_lba),
      .sector_rd_addr (sector_rd_addr),
      .sector_rd_data (sector_rd_data),
      .sector_ack     (sector_ack)
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic void m_reset();
      m_pend = 0; m_staged = 0; m_valid = 0; m_err = 0; m_seq = 0;
      m_plba = '0; m_slba = '0; m_stlba = '0;
      m_rmask = '0; m_smask = '0;
   endfunction

   function automatic void m_req(input logic [23:0] lba);
      if (!m_pend && !m_staged) begin
         m_pend = 1;
         m_plba = lba;
         m_seq  = (m_seq + 1) % 16;
      end
   endfunction

   function automatic void m_set(input logic [23:0] lba, input int n,
                                 input logic [15:0] mask);
      if (n == SW && lba == m_plba && m_pend) begin
         m_pend = 0;
         m_err  = 0;
         if (!m_valid) begin
            m_valid = 1; m_slba = lba; m_rmask = mask;
         end else begin
            m_staged = 1; m_stlba = lba; m_smask = mask;
         end
      end else begin
         m_err = 1;
      end
   endfunction

   function automatic void m_ack();
      if (m_valid) begin
         if (m_staged) begin
            m_staged = 0; m_slba = m_stlba; m_rmask = m_smask;
         end else begin
            m_valid = 0;
         end
      end
   endfunction

   task automatic send(input logic [15:0] w);
      ext_din    = w;
      ext_strobe = 1'b1;
      tick();
      ext_strobe = 1'b0;
   endtask

   task automatic do_req(input logic [23:0] lba);
      req_lba   = lba;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      m_req(lba);
   endtask

   // mode 0: plain; 1: last word with ext_sel fall; 2: ack at commit
   task automatic do_set(input logic [23:0] lba, input int n,
                         input logic [15:0] mask, input int mode);
      ext_cmd = CD_SET;
      ext_sel = 1'b1;
      tick();
      send(lba[15:0]);
      send({8'h00, lba[23:16]});
      chk("set_dout", 32'(ext_dout), 32'h0);
      for (int i = 0; i < n; i++) begin
         if (mode == 1 && i == n - 1) ext_sel = 1'b0;
         send(16'(i) ^ mask);
      end
      if (!(mode == 1 && n > 0)) begin
         ext_sel = 1'b0;
         tick();
      end
      if (mode == 2) sector_ack = 1'b1;
      tick();
      sector_ack = 1'b0;
      if (mode == 2) m_ack();
      m_set(lba, n, mask);
   endtask

   task automatic do_ack();
      logic mid;
      sector_ack = 1'b1;
      tick();
      mid = sector_valid;
      sector_ack = 1'b0;
      tick();
      chk("ack_gap_valid", 32'(mid), 32'h0);
      m_ack();
   endtask

   task automatic do_get(output logic [15:0] w0, output logic [15:0] w1,
                         output logic [15:0] w2, output logic [15:0] w3,
                         output logic [15:0] wz);
      ext_cmd = CD_GET;
      ext_sel = 1'b1;
      tick();
      w0 = ext_dout;
      send(16'h0);
      w1 = ext_dout;
      send(16'h0);
      w2 = ext_dout;
      send(16'h0);
      w3 = ext_dout;
      ext_sel = 1'b0;
      tick();
      wz = ext_dout;
      tick();
   endtask

   task automatic check_state(input string tag, output logic [15:0] w0);
      logic [15:0] w1, w2, w3, wz, exp0;
      logic [10:0] a;
      chk({tag, " ready"}, 32'(req_ready), 32'(!m_pend && !m_staged));
      chk({tag, " valid"}, 32'(sector_valid), 32'(m_valid));
      chk({tag, " lba"}, 32'(sector_lba), 32'(m_slba));
      do_get(w0, w1, w2, w3, wz);
      exp0 = {m_pend, m_staged, m_valid, m_err, 4'(m_seq), 8'h00};
      chk({tag, " w0"}, 32'(w0), 32'(exp0));
      chk({tag, " w1"}, 32'(w1), 32'(m_plba[15:0]));
      chk({tag, " w2"}, 32'(w2), {24'h0, m_plba[23:16]});
      chk({tag, " w3"}, 32'(w3), 32'h0);
      chk({tag, " dout_idle"}, 32'(wz), 32'h0);
      if (m_valid) begin
         for (int j = 0; j < 4; j++) begin
            case (j)
               0:       a = 11'd0;
               1:       a = 11'd5;
               2:       a = 11'(SW - 1);
               default: a = 11'($urandom_range(0, SW - 1));
            endcase
            sector_rd_addr = a;
            tick();
            chk({tag, " rd"}, 32'(sector_rd_data),
                32'({5'b0, a} ^ m_rmask));
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ext_sel = 1'b0;
      ext_strobe = 1'b0;
      req_valid = 1'b0;
      sector_ack = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      m_reset();
   endtask

   initial begin
      logic [15:0] w0;
      int r;

      tbl[0] = '{OP_REQ, 24'h00ABCD, 0, 16'h0, 16'h8100, 1'b0, 24'h0, 1'b0};
      tbl[1] = '{OP_SET, 24'h00ABCD, SW, 16'h0,
                 16'h2100, 1'b1, 24'h00ABCD, 1'b1};
      tbl[2] = '{OP_REQ, 24'h123456, 0, 16'h0,
                 16'hA200, 1'b1, 24'h00ABCD, 1'b0};
      tbl[3] = '{OP_SET, 24'h001234, SW, 16'h1111,
                 16'hB200, 1'b1, 24'h00ABCD, 1'b0};
      tbl[4] = '{OP_SET, 24'h123456, 1000, 16'h2222,
                 16'hB200, 1'b1, 24'h00ABCD, 1'b0};
      tbl[5] = '{OP_SET, 24'h123456, SW, 16'h3333,
                 16'h6200, 1'b1, 24'h00ABCD, 1'b0};
      tbl[6] = '{OP_ACK, 24'h0, 0, 16'h0, 16'h2200, 1'b1, 24'h123456, 1'b1};
      tbl[7] = '{OP_ACK, 24'h0, 0, 16'h0, 16'h0200, 1'b0, 24'h123456, 1'b1};
      tbl[8] = '{OP_ACK, 24'h0, 0, 16'h0, 16'h0200, 1'b0, 24'h123456, 1'b1};

      m_reset();
      repeat (3) tick();
      chk("rst ext_dout", 32'(ext_dout), 32'h0);
      chk("rst req_ready", 32'(req_ready), 32'h0);
      chk("rst valid", 32'(sector_valid), 32'h0);
      chk("rst lba", 32'(sector_lba), 32'h0);
      chk("rst rd_data", 32'(sector_rd_data), 32'h0);
      reset_n = 1'b1;
      tick();
      check_state("post_rst", w0);

      for (int i = 0; i < 9; i++) begin
         case (tbl[i].op)
            OP_REQ:  do_req(tbl[i].lba);
            OP_SET:  do_set(tbl[i].lba, tbl[i].n, tbl[i].mask, 0);
            default: do_ack();
         endcase
         chk($sformatf("tbl%0d ready", i), 32'(req_ready),
             32'(tbl[i].ready));
         chk($sformatf("tbl%0d valid", i), 32'(sector_valid),
             32'(tbl[i].valid));
         chk($sformatf("tbl%0d lba", i), 32'(sector_lba), 32'(tbl[i].slba));
         check_state($sformatf("tbl%0d", i), w0);
         chk($sformatf("tbl%0d w0_const", i), 32'(w0), 32'(tbl[i].w0));
      end

      do_req(24'h0A0B0C);
      do_set(24'h0A0B0C, SW, 16'h4444, 0);
      check_state("seqA1", w0);
      do_req(24'h0D0E0F);
      do_set(24'h0D0E0F, SW, 16'h5555, 2);
      check_state("ack_commit", w0);
      chk("ack_commit staged", 32'(w0[14]), 32'h0);

      do_ack();
      do_req(24'h00FFFF);
      do_set(24'h00FFFF, SW, 16'h6666, 1);
      check_state("last_on_fall", w0);

      do_req(24'h010203);
      do_set(24'h010203, SW + 1, 16'h7777, 0);
      check_state("oversize", w0);

      for (int it = 0; it < 24; it++) begin
         r = $urandom_range(0, 4);
         case (r)
            0: do_req(24'($urandom));
            1: do_set(m_plba, SW, 16'($urandom), $urandom_range(0, 1));
            2: do_set(m_plba, $urandom_range(0, 40), 16'($urandom), 0);
            3: do_set(m_plba ^ 24'(1 << $urandom_range(0, 23)), SW,
                      16'($urandom), 0);
            default: do_ack();
         endcase
         check_state($sformatf("rnd%0d", it), w0);
      end

      do_reset();
      do_req(24'h0055AA);
      do_set(24'h0055AA, SW, 16'h0F0F, 0);
      do_req(24'h000777);
      ext_cmd = CD_SET;
      ext_sel = 1'b1;
      tick();
      for (int i = 0; i < 300; i++) send(16'(i) ^ 16'hF0F0);
      sector_rd_addr = 11'd3;
      tick();
      reset_n = 1'b0;
      #2;
      chk("mid_rst ext_dout", 32'(ext_dout), 32'h0);
      chk("mid_rst req_ready", 32'(req_ready), 32'h0);
      chk("mid_rst valid", 32'(sector_valid), 32'h0);
      chk("mid_rst lba", 32'(sector_lba), 32'h0);
      chk("mid_rst rd_data", 32'(sector_rd_data), 32'h0);
      ext_sel = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      m_reset();
      check_state("after_mid_rst", w0);
      chk("after_mid_rst w0_zero", 32'(w0), 32'h0);

      for (int i = 0; i < 16; i++) begin
         do_req(24'(i + 1));
         do_set(24'(i + 1), SW, 16'(i * 16'h0101), 0);
         do_ack();
         if (i == 14) begin
            check_state("seq15", w0);
            chk("seq15 field", 32'(w0[11:8]), 32'hF);
         end
      end
      check_state("seq_wrap", w0);
      chk("seq_wrap field", 32'(w0[11:8]), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cd_sector_rx.md
Name: cd_sector_rx

Overview:
- Sits directly downstream of the HPS extension-bus command decoder.
- Consumes decoded CD_GET (0x34) and CD_SET (0x35) word streams from the HPS.
- On CD_GET it returns the CD drive core's pending sector request. On CD_SET it stores the delivered 2352-byte raw sector into a two-bank buffer, then hands the sector to the drive core.

Parameters:
- SECTOR_WORDS, 1176, 16-bit payload words per raw sector.
- LBA_W, 24, width of the sector address.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ext_sel  in  1  high while an accepted CD_GET/CD_SET transaction is open, after the command word
- ext_cmd  in  16  latched command word; valid while ext_sel=1
- ext_strobe  in  1  one-cycle pulse per 16-bit data word
- ext_din  in  16  HPS-to-FPGA word, valid with ext_strobe
- ext_dout  out  16  FPGA-to-HPS word
- req_valid  in  1  drive core requests a sector
- req_lba  in  LBA_W  requested sector address
- req_ready  out  1  request accepted when req_valid & req_ready
- sector_valid  out  1  completed sector available in the read bank
- sector_lba  out  LBA_W  address of the read-bank sector
- sector_rd_addr  in  11  word address into the read bank
- sector_rd_data  out  16  read data, 1-cycle latency
- sector_ack  in  1  one-cycle pulse: drive core has finished with the read bank

Behaviour:
- Reset: all registers clear. Outputs: ext_dout=0, req_ready=0 during reset then 1, sector_valid=0, sector_lba=0, sector_rd_data=0. Bank select=0, req_seq=0, err=0, staged=0.
- Reset mid-transfer discards the partial sector and any staged sector.
- Word counter idx (11 bits): cleared on the ext_sel rising edge, increments on each ext_strobe, saturates at 2047.
- Request capture: req_valid & req_ready latches req_lba, sets req_pending, and increments req_seq (4-bit, wraps 15->0).
- req_ready = ~req_pending & ~staged.
- CD_GET status words:
  - w0 = {req_pending, staged, sector_valid, err, req_seq[3:0], 8'h00}
  - w1 = lba[15:0]
  - w2 = zero-extended lba[LBA_W-1:16]
  - w3 onward = 0
- CD_GET timing: on the ext_sel rising edge with CD_GET, ext_dout<=w0. On the strobe for word k, ext_dout<=w(k+1). The status snapshot is taken at the rising edge. ext_dout returns to 0 on the ext_sel falling edge.
- CD_SET payload: w0 = LBA lo, w1 = LBA hi. Words 2..SECTOR_WORDS+1 are written to the write bank at address idx-2. Further words are ignored. ext_dout stays 0.
- CD_SET commit check, on the ext_sel falling edge. Commit only if all hold:
  - idx == SECTOR_WORDS+2
  - received LBA == pending LBA
  - req_pending = 1
- Commit action: req_pending<=0.
  - If sector_valid=0: flip the bank, sector_valid<=1, sector_lba<=LBA, all the next cycle.
  - If sector_valid=1: staged<=1 and the write bank is held.
- Failed commit: data is discarded, err<=1 (sticky, cleared by a successful commit), req_pending is unchanged so the HPS retries.
- sector_ack with staged=0: sector_valid<=0.
- sector_ack with staged=1: sector_valid drops for exactly one cycle, then reasserts with the staged LBA. The bank flips and staged<=0.
- sector_ack while sector_valid=0 is ignored.
- Simultaneous events:
  - strobe and ext_sel fall in the same cycle: the word is processed, commit is evaluated the following cycle.
  - req_valid and commit in the same cycle: req_ready is still 0 (pending), no capture.
  - ack and commit in the same cycle: ack is processed first, so the commit goes straight to sector_valid without staging.
- A CD_SET write never targets the bank being read: the write bank is always ~read bank.
- Commands other than 0x34/0x35 while ext_sel=1 are ignored.

Decomposition:
- Shared package: CD_GET/CD_SET command constants, SECTOR_WORDS, the status-word bit positions, and the LBA_W default.
- One sub-module, cd_sector_ram: simple dual-port 2*SECTOR_WORDS x 16 inferred block RAM. Write port driven from the ext side, registered read port driven by {read bank, sector_rd_addr}.

Test Plan:
- Request then poll: req_lba=0x00ABCD with req_valid -> req_ready drops. CD_GET returns w0=0x8100, w1=0xABCD, w2=0x0000.
- Full delivery: CD_SET with 0xABCD, 0x0000, data=index -> sector_valid=1, sector_lba=0x00ABCD. Reading addr 5 gives 0x0005 one cycle later. req_ready=1.
- Short or mismatched transfer: 1000 data words, or LBA 0x1234 -> no sector_valid. CD_GET w0 has err=1 and req_pending=1.
- Double buffering: a second request is committed while the first sector is unacked -> staged=1, req_ready=0. sector_ack -> exactly one cycle of sector_valid=0, then valid with the new LBA.
- Sequence wrap: 16 completed requests -> req_seq returns to 0. A further CD_GET shows w0[11:8]=0.
- Reset mid-CD_SET after 300 words -> all outputs 0. The next CD_GET returns w0=0x0000.
